calc_core_param: RTL and testbench
==================================

# calc_core_param

Parametrised signed calculator controller; successor to the fixed 16-bit add/sub/mul controller. It accepts keypad digits and one-hot operator keys, evaluates one binary operation, and drives a signed result to the display path. New in this generation:
- configurable width and digit limit
- iterative multiply and restoring divide
- overflow and divide-by-zero flags
- clear key
- result chaining

## Interface
- WIDTH, 16: operand/result width, two's complement, >= 8
- MAX_DIGITS, 5: maximum decimal digits accepted per operand
- clk  in  1  system clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- keypad_input  in  4  BCD digit, sampled on read_input rising edge; values >9 ignored
- read_input  in  1  digit strobe, acted on at its rising edge
- operator_input  in  4  one-hot: 0001 add/negate, 0010 sub, 0100 mul, 1000 div
  - acted on when nonzero, one-hot, and different from the previous cycle's value
- equal_input  in  1  level; evaluate request
- clear_input  in  1  synchronous clear, highest priority
- complete  out  1  result valid (state DONE)
- busy  out  1  high in state EXEC
- overflow  out  1  result not representable in WIDTH bits
- div_zero  out  1  division by zero attempted
- display_output  out  WIDTH  signed value shown

## Operation
- **States:** OP1, OP2, EXEC, DONE. Reset and clear enter OP1.
- **Reset/clear values:** all operands, sign flags, digit counts, op register and outputs are 0.
- **OP1 / OP2 (active operand):**
  - Digit accept: digit count < MAX_DIGITS and the new magnitude mag*10+d does not exceed the limit; otherwise the digit is silently dropped.
    - Limit is 2^(WIDTH-1) if the operand is negative, else 2^(WIDTH-1)-1.
  - A leading 0 counts as a digit, so operand 0 is valid.
  - 0001 with zero digits entered toggles the operand sign.
  - OP1: any legal operator with >= 1 digit latches the op and moves to OP2.
  - OP2: operators after the first digit are ignored.
  - OP2: equal_input high with >= 1 digit moves to EXEC. Equal with zero digits is ignored.
- **Same-cycle priority:** clear > read_input > operator > equal. An operator or equal coinciding with a digit edge is discarded.
- **EXEC:** all inputs except clear ignored.
  - add/sub: 1 cycle, exact WIDTH+1-bit sum.
  - mul: WIDTH-cycle shift-add on magnitudes, 2*WIDTH-bit product, sign = s1 XOR s2.
  - div: WIDTH-cycle restoring divide on magnitudes; quotient truncates toward zero, sign = s1 XOR s2.
  - mul and div each take 1 extra finalise cycle for sign and flags.
- **Flags:**
  - overflow = 1 when the exact result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. This includes -2^(WIDTH-1)/-1. display_output shows the low WIDTH bits of the exact result.
  - div_zero = 1 when the divisor is 0; result 0, overflow 0. The divide is skipped and goes to DONE after the finalise cycle.
- **DONE:** complete = 1; result and flags hold; equal_input ignored.
  - Digit edge: enter OP1, op1 = that digit, flags cleared.
  - Legal operator edge other than 0001-as-negate: chaining. op1 = result (low WIDTH bits), op latched, enter OP2, flags cleared.
  - 0001 in DONE is treated as add (chaining).
- **Display:** OP1 shows signed op1; OP2 shows signed op2 (0 until the first digit or a sign toggle, i.e. shows -0 as 0); EXEC holds the last OP2 value; DONE shows the result.

## Timing
- All outputs are registered and change only on a clk rising edge, except nRST assertion, which zeroes them immediately.
- Edge detection uses 1-cycle registered copies of read_input and operator_input, both cleared by reset.
- A digit edge sampled at edge N updates display_output after edge N+1.
- Equal sampled at edge N (enters EXEC):
  - add/sub: complete rises after edge N+2.
  - mul/div: complete rises after edge N+WIDTH+2.
- busy is high from edge N+1 until the edge at which complete rises. busy and complete are never high together.
- clear_input during EXEC aborts; state is OP1 with zeroed outputs after the next edge.
- nRST low mid-operation aborts asynchronously. After release, the first edge sees state OP1.
- A held operator or read level after a state change does not retrigger; a fresh edge is required.

## Test plan
- Enter -1, 0100, -1, equal -> display 0x0001, overflow 0, complete exactly 18 edges after equal sampled, busy high 17 cycles.
- Enter 128, 0100, 256, equal -> display 0x8000, overflow 1; separately 32767 + 1 -> 0x8000, overflow 1.
- Negate, then digits 3,2,7,6,8, then 0001, then 3,2,7,6,7, equal -> display 0xFFFF, overflow 0. Positive 3,2,7,6,8 entry drops the final 8 (op1 = 3276), and a sixth digit is always dropped.
- 7 / 0 -> div_zero 1, display 0. -7 / 2 -> 0xFFFD. -32768 / -1 -> 0x8000 with overflow 1.
- 5 + 3 equal -> 8; then 0100, 4, equal -> 32 (chaining); then digit 9 in DONE -> OP1 showing 9, flags 0.
- Assert clear mid-multiply (cycle 5 of EXEC) -> all outputs 0 next edge, state OP1. Pulse nRST low during OP2 entry -> outputs 0 immediately, and a clean 2 + 3 = 5 follows.

Source files
------------

// File: rtl/calc_core_param_if.sv
// rtl/calc_core_param_if.sv - keypad/operator inputs and result outputs of calc_core_param
interface calc_core_param_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       keypad_input;
    logic             read_input;
    logic [3:0]       operator_input;
    logic             equal_input;
    logic             clear_input;
    logic             complete;
    logic             busy;
    logic             overflow;
    logic             div_zero;
    logic [WIDTH-1:0] display_output;

    modport master (
        output keypad_input, read_input, operator_input, equal_input, clear_input,
        input  complete, busy, overflow, div_zero, display_output
    );

    modport slave (
        input  keypad_input, read_input, operator_input, equal_input, clear_input,
        output complete, busy, overflow, div_zero, display_output
    );
endinterface

// File: rtl/calc_core_param.sv
// rtl/calc_core_param.sv - parametrised signed keypad calculator: digit entry, add/sub,
// iterative multiply, restoring divide, overflow/div-by-zero flags and result chaining
module calc_core_param #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input logic              clk,
    input logic              nRST,
    calc_core_param_if.slave bus
);
    localparam logic [1:0] ST_OP1  = 2'd0;
    localparam logic [1:0] ST_OP2  = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    localparam int MW = WIDTH + 5;
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int NW = $clog2(WIDTH + 1);

    localparam logic [MW-1:0] POS_LIM = (MW'(1) << (WIDTH - 1)) - MW'(1);
    localparam logic [DW-1:0] HALF    = DW'(1) << (WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic             op1_neg, op2_neg;
    logic [CW-1:0]    op1_cnt, op2_cnt;
    logic [3:0]       op;
    logic             read_q;
    logic [3:0]       oper_q;
    logic [NW-1:0]    step;
    logic [DW-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplier, quo, rem;
    logic [WIDTH-1:0] res;
    logic             res_ovf, res_dz;

    logic             read_edge, oper_edge, oper_legal;
    logic [3:0]       oper;
    logic             act_op2;
    logic [WIDTH-1:0] act_mag;
    logic             act_neg;
    logic [CW-1:0]    act_cnt;
    logic [MW-1:0]    cand, limit;
    logic             digit_ok;
    logic [WIDTH-1:0] op1_val, op2_val;
    logic [WIDTH:0]   sum;
    logic             res_neg;
    logic [DW-1:0]    fin_mag;
    logic [WIDTH-1:0] fin_low;
    logic             fin_ovf;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] res_mag;
    logic [WIDTH-1:0] disp_next;

    always_comb begin
        oper       = bus.operator_input;
        oper_legal = (oper != 4'd0) && ((oper & (oper - 4'd1)) == 4'd0);
        read_edge  = bus.read_input && !read_q;
        oper_edge  = oper_legal && (oper != oper_q);

        act_op2  = (state == ST_OP2);
        act_mag  = act_op2 ? op2_mag : op1_mag;
        act_neg  = act_op2 ? op2_neg : op1_neg;
        act_cnt  = act_op2 ? op2_cnt : op1_cnt;
        // a negative operand may reach one further than a positive one
        cand     = MW'(act_mag) * MW'(10) + MW'(bus.keypad_input);
        limit    = act_neg ? POS_LIM + MW'(1) : POS_LIM;
        digit_ok = (bus.keypad_input <= 4'd9) && (act_cnt < CW'(MAX_DIGITS)) && (cand <= limit);

        op1_val = op1_neg ? -op1_mag : op1_mag;
        op2_val = op2_neg ? -op2_mag : op2_mag;
        sum     = {op1_val[WIDTH-1], op1_val} +
                  ((op == OP_SUB) ? -{op2_val[WIDTH-1], op2_val} : {op2_val[WIDTH-1], op2_val});

        res_neg = op1_neg ^ op2_neg;
        fin_mag = (op == OP_MUL) ? acc : DW'(quo);
        fin_low = res_neg ? -fin_mag[WIDTH-1:0] : fin_mag[WIDTH-1:0];
        fin_ovf = res_neg ? (fin_mag > HALF) : (fin_mag > HALF - DW'(1));

        // remainder stays below the divisor, so the low WIDTH bits of the difference are exact
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh[WIDTH-1:0] - op2_mag;

        res_mag = res[WIDTH-1] ? -res : res;

        case (state)
            ST_OP1:  disp_next = op1_val;
            ST_DONE: disp_next = res;
            default: disp_next = op2_val;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_OP1;
            op1_mag <= '0;
            op2_mag <= '0;
            op1_neg <= 1'b0;
            op2_neg <= 1'b0;
            op1_cnt <= '0;
            op2_cnt <= '0;
            op      <= 4'd0;
            read_q  <= 1'b0;
            oper_q  <= 4'd0;
            step    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            res     <= '0;
            res_ovf <= 1'b0;
            res_dz  <= 1'b0;
            bus.display_output <= '0;
            bus.complete       <= 1'b0;
            bus.busy           <= 1'b0;
            bus.overflow       <= 1'b0;
            bus.div_zero       <= 1'b0;
        end else begin
            read_q <= bus.read_input;
            oper_q <= bus.operator_input;

            bus.display_output <= disp_next;
            bus.complete       <= (state == ST_DONE);
            bus.busy           <= (state == ST_EXEC);
            bus.overflow       <= (state == ST_DONE) && res_ovf;
            bus.div_zero       <= (state == ST_DONE) && res_dz;

            if (bus.clear_input) begin
                state   <= ST_OP1;
                op1_mag <= '0;
                op2_mag <= '0;
                op1_neg <= 1'b0;
                op2_neg <= 1'b0;
                op1_cnt <= '0;
                op2_cnt <= '0;
                op      <= 4'd0;
                step    <= '0;
                acc     <= '0;
                mcand   <= '0;
                mplier  <= '0;
                quo     <= '0;
                rem     <= '0;
                res     <= '0;
                res_ovf <= 1'b0;
                res_dz  <= 1'b0;
                bus.display_output <= '0;
                bus.complete       <= 1'b0;
                bus.busy           <= 1'b0;
                bus.overflow       <= 1'b0;
                bus.div_zero       <= 1'b0;
            end else begin
                case (state)
                    ST_OP1, ST_OP2: begin
                        if (read_edge) begin
                            if (digit_ok && !act_op2) begin
                                op1_mag <= cand[WIDTH-1:0];
                                op1_cnt <= op1_cnt + CW'(1);
                            end else if (digit_ok) begin
                                op2_mag <= cand[WIDTH-1:0];
                                op2_cnt <= op2_cnt + CW'(1);
                            end
                        end else if (oper_edge) begin
                            if (oper == OP_ADD && act_cnt == '0) begin
                                if (act_op2) op2_neg <= !op2_neg;
                                else         op1_neg <= !op1_neg;
                            end else if (!act_op2 && op1_cnt != '0) begin
                                op      <= oper;
                                op2_mag <= '0;
                                op2_neg <= 1'b0;
                                op2_cnt <= '0;
                                state   <= ST_OP2;
                            end
                        end else if (act_op2 && bus.equal_input && op2_cnt != '0) begin
                            step   <= '0;
                            acc    <= '0;
                            mcand  <= DW'(op1_mag);
                            mplier <= op2_mag;
                            quo    <= op1_mag;
                            rem    <= '0;
                            state  <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (op == OP_ADD || op == OP_SUB) begin
                            res     <= sum[WIDTH-1:0];
                            res_ovf <= sum[WIDTH] ^ sum[WIDTH-1];
                            res_dz  <= 1'b0;
                            state   <= ST_DONE;
                        end else if (op == OP_DIV && op2_mag == '0) begin
                            res     <= '0;
                            res_ovf <= 1'b0;
                            res_dz  <= 1'b1;
                            state   <= ST_DONE;
                        end else if (step != NW'(WIDTH)) begin
                            step <= step + NW'(1);
                            if (op == OP_MUL) begin
                                if (mplier[0]) acc <= acc + mcand;
                                mcand  <= mcand << 1;
                                mplier <= mplier >> 1;
                            end else if (rem_sh >= {1'b0, op2_mag}) begin
                                rem <= rem_diff;
                                quo <= {quo[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= rem_sh[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            res     <= fin_low;
                            res_ovf <= fin_ovf;
                            res_dz  <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end
                    default: begin
                        if (read_edge) begin
                            if (bus.keypad_input <= 4'd9) begin
                                op1_mag <= WIDTH'(bus.keypad_input);
                                op1_neg <= 1'b0;
                                op1_cnt <= CW'(1);
                                op2_mag <= '0;
                                op2_neg <= 1'b0;
                                op2_cnt <= '0;
                                op      <= 4'd0;
                                res     <= '0;
                                res_ovf <= 1'b0;
                                res_dz  <= 1'b0;
                                state   <= ST_OP1;
                            end
                        end else if (oper_edge) begin
                            // chaining: the shown WIDTH-bit result becomes the first operand
                            op1_mag <= res_mag;
                            op1_neg <= res[WIDTH-1];
                            op1_cnt <= CW'(1);
                            op2_mag <= '0;
                            op2_neg <= 1'b0;
                            op2_cnt <= '0;
                            op      <= oper;
                            res_ovf <= 1'b0;
                            res_dz  <= 1'b0;
                            state   <= ST_OP2;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_core_param.sv
// tb/tb_calc_core_param.sv - randomized and directed checks of calc_core_param against an
// integer-arithmetic model of the calculator
module tb_calc_core_param;
    localparam int W    = 16;
    localparam int MAXD = 5;
    localparam longint HALF = longint'(1) << (W - 1);
    localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, MUL = 4'b0100, DIV = 4'b1000;
    localparam int M_OP1 = 0, M_OP2 = 1, M_DONE = 2;

    logic clk, nRST;
    calc_core_param_if #(.WIDTH(W)) bus ();
    calc_core_param #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (.clk(clk), .nRST(nRST), .bus(bus));

    int n_tests, n_fail;

    longint     m_mag [2];
    bit         m_neg [2];
    int         m_cnt [2];
    int         m_cur, m_st;
    logic [3:0] m_op;
    longint     m_res;
    bit         m_ovf, m_dz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] low(input longint v);
        return v[W-1:0];
    endfunction

    function automatic longint sval(input int i);
        return m_neg[i] ? -m_mag[i] : m_mag[i];
    endfunction

    function automatic logic [W-1:0] exp_disp();
        if (m_st == M_DONE) return low(m_res);
        return low(sval(m_cur));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_mag[i] = 0; m_neg[i] = 0; m_cnt[i] = 0;
        end
        m_cur = 0; m_st = M_OP1; m_op = 4'd0; m_res = 0; m_ovf = 0; m_dz = 0;
    endtask

    task automatic m_start_op2(input logic [3:0] o);
        m_op = o; m_st = M_OP2; m_cur = 1;
        m_mag[1] = 0; m_neg[1] = 0; m_cnt[1] = 0;
    endtask

    task automatic m_digit(input int d);
        longint nm, lim;
        if (m_st == M_DONE) begin
            if (d <= 9) begin
                m_st = M_OP1; m_cur = 0;
                m_mag[0] = d; m_neg[0] = 0; m_cnt[0] = 1;
                m_res = 0; m_ovf = 0; m_dz = 0;
            end
        end else if (d <= 9 && m_cnt[m_cur] < MAXD) begin
            nm  = m_mag[m_cur] * 10 + d;
            lim = m_neg[m_cur] ? HALF : HALF - 1;
            if (nm <= lim) begin
                m_mag[m_cur] = nm;
                m_cnt[m_cur]++;
            end
        end
    endtask

    task automatic m_oper(input logic [3:0] o);
        logic [W-1:0] lw;
        if (m_st == M_DONE) begin
            lw = low(m_res);
            m_neg[0] = lw[W-1];
            m_mag[0] = lw[W-1] ? 2 * HALF - longint'(lw) : longint'(lw);
            m_cnt[0] = 1;
            m_ovf = 0; m_dz = 0;
            m_start_op2(o);
        end else if (o == ADD && m_cnt[m_cur] == 0) begin
            m_neg[m_cur] = !m_neg[m_cur];
        end else if (m_st == M_OP1 && m_cnt[0] > 0) begin
            m_start_op2(o);
        end
    endtask

    task automatic m_eval(output int lat);
        longint a, b, r;
        a = sval(0); b = sval(1); m_dz = 0;
        case (m_op)
            ADD: r = a + b;
            SUB: r = a - b;
            MUL: r = a * b;
            default: begin
                if (b == 0) begin r = 0; m_dz = 1; end
                else r = a / b;
            end
        endcase
        m_ovf = !m_dz && (r < -HALF || r > HALF - 1);
        m_res = r;
        m_st  = M_DONE;
        lat   = (m_op == ADD || m_op == SUB || m_dz) ? 2 : W + 2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_display"}, bus.display_output, exp_disp());
        check({tag, "_overflow"}, bus.overflow, (m_st == M_DONE) && m_ovf);
        check({tag, "_div_zero"}, bus.div_zero, (m_st == M_DONE) && m_dz);
        check({tag, "_complete"}, bus.complete, m_st == M_DONE);
    endtask

    task automatic press_digit(input int d);
        bus.keypad_input = 4'(d);
        bus.read_input = 1'b1;
        tick();
        bus.read_input = 1'b0;
        tick();
        m_digit(d);
        check_all("digit");
    endtask

    task automatic press_op(input logic [3:0] o);
        bus.operator_input = o;
        tick();
        bus.operator_input = 4'd0;
        tick();
        m_oper(o);
        check_all("oper");
    endtask

    task automatic do_clear();
        bus.clear_input = 1'b1;
        tick();
        bus.clear_input = 1'b0;
        m_reset();
        check_all("clear");
    endtask

    task automatic do_equal();
        int lat, nbusy, exp_lat;
        bit both, done;
        m_eval(exp_lat);
        bus.equal_input = 1'b1;
        tick();
        bus.equal_input = 1'b0;
        lat = 0; nbusy = 0; both = 0; done = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
            if (bus.busy) nbusy++;
            if (bus.busy && bus.complete) both = 1;
            if (bus.complete) done = 1;
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", nbusy, exp_lat - 1);
        check("busy_complete_overlap", both, 0);
        check_all("result");
    endtask

    task automatic enter(input bit neg, input logic [23:0] digs, input int n);
        if (neg) press_op(ADD);
        for (int i = n - 1; i >= 0; i--) press_digit(int'(digs[i*4 +: 4]));
    endtask

    task automatic calc(input bit n1, input logic [23:0] d1, input int k1, input logic [3:0] o,
                        input bit n2, input logic [23:0] d2, input int k2);
        enter(n1, d1, k1);
        press_op(o);
        enter(n2, d2, k2);
        do_equal();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        nRST = 1'b0;
        bus.keypad_input = 4'd0; bus.read_input = 1'b0; bus.operator_input = 4'd0;
        bus.equal_input = 1'b0; bus.clear_input = 1'b0;
        m_reset();
        #22;
        check("reset_display", bus.display_output, 0);
        check("reset_complete", bus.complete, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_overflow", bus.overflow, 0);
        check("reset_div_zero", bus.div_zero, 0);
        nRST = 1'b1;
        tick();
        check_all("post_reset");

        do_clear(); calc(1, 24'h1, 1, MUL, 1, 24'h1, 1);
        check("m1_x_m1", bus.display_output, 16'h0001);
        do_clear(); calc(0, 24'h128, 3, MUL, 0, 24'h256, 3);
        check("mul_ovf_disp", bus.display_output, 16'h8000);
        check("mul_ovf_flag", bus.overflow, 1);
        do_clear(); calc(0, 24'h32767, 5, ADD, 0, 24'h1, 1);
        check("add_ovf_disp", bus.display_output, 16'h8000);
        check("add_ovf_flag", bus.overflow, 1);
        do_clear(); calc(1, 24'h32768, 5, ADD, 0, 24'h32767, 5);
        check("min_plus_max", bus.display_output, 16'hFFFF);
        check("min_plus_max_ovf", bus.overflow, 0);
        do_clear(); enter(0, 24'h32768, 5);
        check("drop_over_limit", bus.display_output, 3276);
        do_clear(); enter(0, 24'h123456, 6);
        check("drop_sixth_digit", bus.display_output, 12345);
        do_clear(); calc(0, 24'h7, 1, DIV, 0, 24'h0, 1);
        check("div_zero_flag", bus.div_zero, 1);
        check("div_zero_disp", bus.display_output, 0);
        do_clear(); calc(1, 24'h7, 1, DIV, 0, 24'h2, 1);
        check("neg7_div_2", bus.display_output, 16'hFFFD);
        do_clear(); calc(1, 24'h32768, 5, DIV, 1, 24'h1, 1);
        check("min_div_m1", bus.display_output, 16'h8000);
        check("min_div_m1_ovf", bus.overflow, 1);

        do_clear(); calc(0, 24'h5, 1, ADD, 0, 24'h3, 1);
        check("five_plus_three", bus.display_output, 8);
        press_op(MUL);
        press_digit(4);
        do_equal();
        check("chain_result", bus.display_output, 32);
        press_digit(9);
        check("done_digit", bus.display_output, 9);

        do_clear(); enter(0, 24'h12, 2); press_op(MUL); enter(0, 24'h34, 2);
        bus.equal_input = 1'b1;
        tick();
        bus.equal_input = 1'b0;
        repeat (4) tick();
        check("mid_mul_busy", bus.busy, 1);
        bus.clear_input = 1'b1;
        tick();
        bus.clear_input = 1'b0;
        m_reset();
        check_all("abort");
        check("abort_busy", bus.busy, 0);
        press_digit(7);

        do_clear(); enter(0, 24'h4, 1); press_op(ADD); press_digit(6);
        check("pre_reset_disp", bus.display_output, 6);
        #3 nRST = 1'b0;
        #1;
        check("async_reset_disp", bus.display_output, 0);
        check("async_reset_complete", bus.complete, 0);
        check("async_reset_busy", bus.busy, 0);
        #2 nRST = 1'b1;
        m_reset();
        calc(0, 24'h2, 1, ADD, 0, 24'h3, 1);
        check("two_plus_three", bus.display_output, 5);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] o;
            int k;
            do_clear();
            if ($urandom % 4 == 0) press_op(ADD);
            k = 1 + int'($urandom % 6);
            for (int i = 0; i < k; i++) begin
                int d;
                d = (i > 0 && $urandom % 8 == 0) ? 10 + int'($urandom % 6) : int'($urandom % 10);
                press_digit(d);
            end
            o = 4'b0001 << ($urandom % 4);
            press_op(o);
            if ($urandom % 4 == 0) press_op(ADD);
            if (o == DIV && $urandom % 4 == 0) begin
                press_digit(0);
            end else begin
                k = 1 + int'($urandom % 6);
                for (int i = 0; i < k; i++) press_digit(int'($urandom % 10));
            end
            if ($urandom % 3 == 0) press_op(4'b0001 << ($urandom % 4));
            do_equal();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
